// File: rtl/ysyx_22041752_mul_ctrl_pkg.sv
// rtl/ysyx_22041752_mul_ctrl_pkg.sv - shared op/state encodings for the multiply controller
package ysyx_22041752_mul_ctrl_pkg;

    localparam int XLEN_DEFAULT = 64;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_MULW   = 3'd4
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Codes 5-7 behave as MUL; normalising here keeps cache keys consistent.
    function automatic op_t norm_op(input logic [2:0] code);
        case (code)
            3'd1:    norm_op = OP_MULH;
            3'd2:    norm_op = OP_MULHSU;
            3'd3:    norm_op = OP_MULHU;
            3'd4:    norm_op = OP_MULW;
            default: norm_op = OP_MUL;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22041752_mul_ctrl_cache.sv
// rtl/ysyx_22041752_mul_ctrl_cache.sv - one-entry last-result cache with match compare
module ysyx_22041752_mul_cache
    import ysyx_22041752_mul_ctrl_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  op_t             wr_op,
    input  logic [XLEN-1:0] wr_src1,
    input  logic [XLEN-1:0] wr_src2,
    input  logic [XLEN-1:0] wr_result,
    input  op_t             rd_op,
    input  logic [XLEN-1:0] rd_src1,
    input  logic [XLEN-1:0] rd_src2,
    output logic            hit,
    output logic [XLEN-1:0] rd_result
);

    logic            valid_q;
    op_t             op_q;
    logic [XLEN-1:0] src1_q;
    logic [XLEN-1:0] src2_q;
    logic [XLEN-1:0] result_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            op_q     <= OP_MUL;
            src1_q   <= '0;
            src2_q   <= '0;
            result_q <= '0;
        end else if (wr_en) begin
            valid_q  <= 1'b1;
            op_q     <= wr_op;
            src1_q   <= wr_src1;
            src2_q   <= wr_src2;
            result_q <= wr_result;
        end
    end

    assign hit       = valid_q && (op_q == rd_op) && (src1_q == rd_src1) && (src2_q == rd_src2);
    assign rd_result = result_q;

endmodule

// File: rtl/ysyx_22041752_mul_ctrl.sv
// rtl/ysyx_22041752_mul_ctrl.sv - execute-stage sequencer for the iterative RV64M multiplier
module ysyx_22041752_mul_ctrl
    import ysyx_22041752_mul_ctrl_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int TAG_W    = 5,
    parameter int CACHE_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_src1,
    input  logic [XLEN-1:0]  in_src2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             m_valid,
    output logic             m_u,
    output logic             m_su,
    output logic             m_h,
    output logic             m_flush,
    output logic [XLEN-1:0]  m_src1,
    output logic [XLEN-1:0]  m_src2,
    input  logic             m_done,
    input  logic [XLEN-1:0]  m_product
);

    state_t          state, state_nxt;
    op_t             req_op;
    op_t             in_op_n;
    logic [XLEN-1:0] req_src1;
    logic [XLEN-1:0] req_src2;
    logic            accept;
    logic            cache_match;
    logic            hit;
    logic            cache_wr;
    logic [XLEN-1:0] cache_result;
    logic [XLEN-1:0] final_result;

    assign in_op_n  = norm_op(in_op);
    assign in_ready = (state == ST_IDLE) && !reset;
    assign accept   = in_ready && in_valid && !flush;
    assign hit      = (CACHE_EN != 0) && cache_match;
    // A completion in the same cycle as a flush is discarded and must not pollute the cache.
    assign cache_wr = (state == ST_BUSY) && m_done && !flush;

    assign final_result = (req_op == OP_MULW) ?
                          {{(XLEN-32){m_product[31]}}, m_product[31:0]} : m_product;

    ysyx_22041752_mul_cache #(.XLEN(XLEN)) u_cache (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (cache_wr),
        .wr_op     (req_op),
        .wr_src1   (req_src1),
        .wr_src2   (req_src2),
        .wr_result (final_result),
        .rd_op     (in_op_n),
        .rd_src1   (in_src1),
        .rd_src2   (in_src2),
        .hit       (cache_match),
        .rd_result (cache_result)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = hit ? ST_DONE : ST_BUSY;
            ST_BUSY: if (m_done) state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (flush) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            m_valid    <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            req_op     <= OP_MUL;
            req_src1   <= '0;
            req_src2   <= '0;
        end else begin
            state     <= state_nxt;
            m_valid   <= (state_nxt == ST_BUSY);
            out_valid <= (state_nxt == ST_DONE);
            if (accept) begin
                req_op   <= in_op_n;
                req_src1 <= in_src1;
                req_src2 <= in_src2;
                out_tag  <= in_tag;
                if (hit) out_result <= cache_result;
            end
            if (cache_wr) out_result <= final_result;
        end
    end

    always_comb begin
        m_u  = 1'b0;
        m_su = 1'b0;
        m_h  = 1'b0;
        case (req_op)
            OP_MULH:   m_h = 1'b1;
            OP_MULHSU: begin m_su = 1'b1; m_h = 1'b1; end
            OP_MULHU:  begin m_u = 1'b1; m_h = 1'b1; end
            default:   ;
        endcase
    end

    assign m_flush = flush;
    assign m_src1  = req_src1;
    assign m_src2  = req_src2;

endmodule

// File: tb/tb_ysyx_22041752_mul_ctrl.sv
// tb/tb_ysyx_22041752_mul_ctrl.sv - directed self-checking bench for the multiply controller
module tb_ysyx_22041752_mul_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = 3'd0;
    logic [63:0] in_src1 = '0;
    logic [63:0] in_src2 = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_result;
    logic [4:0]  out_tag;
    logic        m_valid, m_u, m_su, m_h, m_flush;
    logic [63:0] m_src1, m_src2;
    logic        m_done;
    logic [63:0] m_product;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ysyx_22041752_mul_ctrl dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag),
        .m_valid(m_valid), .m_u(m_u), .m_su(m_su), .m_h(m_h), .m_flush(m_flush),
        .m_src1(m_src1), .m_src2(m_src2), .m_done(m_done), .m_product(m_product)
    );

    // Iterative multiplier stand-in: 66 cycles of mul_valid, or immediate on a zero operand.
    int           mcnt = 0;
    logic [127:0] ma, mb, mfull;
    always @(posedge clk) begin
        if (!m_valid || m_flush) mcnt <= 0;
        else                     mcnt <= mcnt + 1;
    end
    assign m_done = m_valid && ((m_src1 == 64'd0) || (m_src2 == 64'd0) || (mcnt == 65));
    always_comb begin
        ma = m_u ? {64'd0, m_src1} : {{64{m_src1[63]}}, m_src1};
        mb = (m_u || m_su) ? {64'd0, m_src2} : {{64{m_src2[63]}}, m_src2};
        mfull = ma * mb;
        m_product = m_h ? mfull[127:64] : mfull[63:0];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] tg);
        in_op = op; in_src1 = a; in_src2 = b; in_tag = tg; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Returns latency (cycles from accept to out_valid) and count of m_valid-high cycles.
    task automatic wait_out(output int lat, output int mv);
        lat = 1; mv = 0;
        while (lat < 200) begin
            if (m_valid) mv++;
            if (out_valid) break;
            step();
            lat++;
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] tg, input logic [63:0] exp,
                          input int exp_lat, input int exp_mv);
        int lat, mv;
        issue(op, a, b, tg);
        wait_out(lat, mv);
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        check({name, "_mvalid_cycles"}, 64'(mv), 64'(exp_mv));
        check({name, "_result"}, out_result, exp);
        check({name, "_tag"}, 64'(out_tag), 64'(tg));
        step();
        check({name, "_out_valid_drop"}, 64'(out_valid), 64'd0);
        check({name, "_in_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int   lat, mv, seen;
        logic [63:0] held;
        logic stable;

        // reset values
        step(); step();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_out_result", out_result, 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        run_op("mul_3x5", 3'd0, 64'd3, 64'd5, 5'd7, 64'd15, 67, 66);
        run_op("mul_zero", 3'd0, 64'd0, 64'h1234, 5'd1, 64'd0, 2, 1);
        run_op("mulhu_ones", 3'd3, '1, '1, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE, 67, 66);
        run_op("mulw", 3'd4, 64'h7FFF_FFFF, 64'd2, 5'd3, 64'hFFFF_FFFF_FFFF_FFFE, 67, 66);
        run_op("mulw_hit", 3'd4, 64'h7FFF_FFFF, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0);
        run_op("mulhsu", 3'd2, '1, 64'd2, 5'd5, '1, 67, 66);
        run_op("illegal_op7", 3'd7, 64'd6, 64'd7, 5'd6, 64'd42, 67, 66);

        // flush in IDLE blocks acceptance
        in_op = 3'd0; in_src1 = 64'd11; in_src2 = 64'd13; in_valid = 1'b1; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        check("idle_flush_m_valid", 64'(m_valid), 64'd0);
        check("idle_flush_in_ready", 64'(in_ready), 64'd1);

        // flush mid-BUSY
        issue(3'd0, 64'd7, 64'd9, 5'd8);
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_m_valid", 64'(m_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 70; i++) begin
            if (out_valid || m_valid) seen++;
            step();
        end
        check("flush_no_output", 64'(seen), 64'd0);
        run_op("reissue_7x9", 3'd0, 64'd7, 64'd9, 5'd9, 64'd63, 67, 66);

        // backpressure in DONE, then reset
        out_ready = 1'b0;
        issue(3'd1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 5'd10);
        wait_out(lat, mv);
        check("bp_latency", 64'(lat), 64'd67);
        check("bp_result", out_result, '1);
        held = out_result;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!out_valid || in_ready || out_result !== held) stable = 1'b0;
        end
        check("bp_stable", 64'(stable), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("bp_reset_out_valid", 64'(out_valid), 64'd0);
        check("bp_reset_out_result", out_result, 64'd0);
        out_ready = 1'b1;
        run_op("after_reset_miss", 3'd1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 5'd10, '1, 67, 66);

        // flush in DONE wins over out_ready
        out_ready = 1'b0;
        issue(3'd0, 64'd2, 64'd21, 5'd11);
        wait_out(lat, mv);
        check("done_flush_pre", 64'(out_valid), 64'd1);
        out_ready = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0;
        check("done_flush_out_valid", 64'(out_valid), 64'd0);
        check("done_flush_in_ready", 64'(in_ready), 64'd1);
        run_op("done_flush_cache_kept", 3'd0, 64'd2, 64'd21, 5'd12, 64'd42, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
